// File: rtl/lasx_bank.sv
// lasx_bank: DEPTH x WIDTH storage bank with a synchronous preset on reset
// and a multi-cycle set sweep that presets one entry per cycle.
// Read port is registered, with optional same-cycle write-to-read forwarding
// and complementary Q/QN outputs.
// Optional feature macro: LASX_BANK_PARITY_EN adds a per-entry even-parity
// bit, an ERR_INJ input and a PERR output.
module lasx_bank #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter int               AW      = 2,
    parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}},
    parameter bit               BYPASS  = 1'b1
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             WE,
    input  logic [AW-1:0]    WADDR,
    input  logic [WIDTH-1:0] D,
    input  logic [AW-1:0]    RADDR,
    input  logic             SETREQ,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             BUSY,
    output logic             DONE
`ifdef LASX_BANK_PARITY_EN
    ,
    input  logic             ERR_INJ,
    output logic             PERR
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_ptr;
    logic [AW-1:0]    w_ptr_nxt;
    logic             w_done_nxt;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_qn;
    logic             r_busy;
    logic             r_done;

    logic             w_sweep;
    logic             w_waddr_ok;
    logic             w_raddr_ok;
    logic             w_wr_eff;
    logic             w_rd_fwd;
    logic [WIDTH-1:0] w_rd_data;

    assign w_sweep    = (r_state == ST_SWEEP);
    assign w_waddr_ok = (32'(WADDR) < 32'(DEPTH));
    assign w_raddr_ok = (32'(RADDR) < 32'(DEPTH));
    // A write landing on the entry being swept loses: the bank is set-dominant.
    assign w_wr_eff   = WE && w_waddr_ok && !(w_sweep && (WADDR == r_ptr));

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            r_state <= ST_IDLE;
            r_ptr   <= {AW{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // FSM next-state: IDLE waits for SETREQ, SWEEP walks ptr 0..DEPTH-1
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (SETREQ) begin
                    w_state_nxt = ST_SWEEP;
                    w_ptr_nxt   = {AW{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (r_ptr == AW'(DEPTH - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = {AW{1'b0}};
                    w_done_nxt  = 1'b1;
                end else begin
                    w_ptr_nxt   = r_ptr + AW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = {AW{1'b0}};
            end
        endcase
    end

    // Read mux: out-of-range reads return SET_VAL; forwarding shows the value being written
    always_comb begin
        w_rd_data = SET_VAL;
        w_rd_fwd  = 1'b0;
        if (!w_raddr_ok) begin
            w_rd_data = SET_VAL;
        end else if (BYPASS && w_sweep && (RADDR == r_ptr)) begin
            w_rd_data = SET_VAL;
            w_rd_fwd  = 1'b1;
        end else if (BYPASS && w_wr_eff && (WADDR == RADDR)) begin
            w_rd_data = D;
            w_rd_fwd  = 1'b1;
        end else begin
            w_rd_data = r_mem[RADDR];
        end
    end

    // Storage array: reset presets everything, sweep presets entry ptr
    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= SET_VAL;
            end
        end else begin
            if (w_wr_eff) begin
                r_mem[WADDR] <= D;
            end
            if (w_sweep) begin
                r_mem[r_ptr] <= SET_VAL;
            end
        end
    end

    // Registered outputs: read data, its complement, sweep status
    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            r_q    <= SET_VAL;
            r_qn   <= ~SET_VAL;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_q    <= w_rd_data;
            r_qn   <= ~w_rd_data;
            r_busy <= (w_state_nxt == ST_SWEEP);
            r_done <= w_done_nxt;
        end
    end

    assign Q    = r_q;
    assign QN   = r_qn;
    assign BUSY = r_busy;
    assign DONE = r_done;

`ifdef LASX_BANK_PARITY_EN
    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic even_par(input logic [WIDTH-1:0] data);
        return ^data;
    endfunction

    logic [DEPTH-1:0] r_par;
    logic             r_perr;
    logic             w_perr_nxt;

    // Parity check of the entry being read; forwarded and out-of-range reads never flag
    always_comb begin
        w_perr_nxt = 1'b0;
        if (!w_raddr_ok || w_rd_fwd) begin
            w_perr_nxt = 1'b0;
        end else begin
            w_perr_nxt = even_par(r_mem[RADDR]) ^ r_par[RADDR];
        end
    end

    // Parity storage tracks the data array; ERR_INJ corrupts the written bit
    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            r_par  <= {DEPTH{even_par(SET_VAL)}};
            r_perr <= 1'b0;
        end else begin
            if (w_wr_eff) begin
                r_par[WADDR] <= even_par(D) ^ ERR_INJ;
            end
            if (w_sweep) begin
                r_par[r_ptr] <= even_par(SET_VAL);
            end
            r_perr <= w_perr_nxt;
        end
    end

    assign PERR = r_perr;
`else
    logic w_unused_fwd;
    assign w_unused_fwd = w_rd_fwd;
`endif

endmodule

// File: tb/tb_lasx_bank.sv
// Self-checking bench for lasx_bank. Two instances share the stimulus:
// inst 0 = WIDTH 8, DEPTH 4, BYPASS 1; inst 1 = WIDTH 8, DEPTH 3 (not a
// power of two, address 3 out of range), BYPASS 0. A countdown-based
// reference model predicts every registered output.
module tb_lasx_bank;

    logic       clk = 1'b0;
    logic       rstb, we, setreq, err_inj;
    logic [1:0] waddr, raddr;
    logic [7:0] d;
    logic [7:0] q0, qn0, q1, qn1;
    logic       busy0, done0, busy1, done1;
`ifdef LASX_BANK_PARITY_EN
    logic       perr0, perr1;
`endif

    always #5 clk = ~clk;

    lasx_bank #(.WIDTH(8), .DEPTH(4), .AW(2), .SET_VAL(8'hFF), .BYPASS(1'b1)) u_dut0 (
        .CLK(clk), .RSTB(rstb), .WE(we), .WADDR(waddr), .D(d), .RADDR(raddr),
        .SETREQ(setreq), .Q(q0), .QN(qn0), .BUSY(busy0), .DONE(done0)
`ifdef LASX_BANK_PARITY_EN
        , .ERR_INJ(err_inj), .PERR(perr0)
`endif
    );

    lasx_bank #(.WIDTH(8), .DEPTH(3), .AW(2), .SET_VAL(8'hFF), .BYPASS(1'b0)) u_dut1 (
        .CLK(clk), .RSTB(rstb), .WE(we), .WADDR(waddr), .D(d), .RADDR(raddr),
        .SETREQ(setreq), .Q(q1), .QN(qn1), .BUSY(busy1), .DONE(done1)
`ifdef LASX_BANK_PARITY_EN
        , .ERR_INJ(err_inj), .PERR(perr1)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state, per instance
    int         depth [2] = '{4, 3};
    bit         byp   [2] = '{1'b1, 1'b0};
    logic [7:0] mmem  [2][4];
    bit         mpar  [2][4];
    int         left  [2];   // entries still to be preset; 0 = idle
    logic [7:0] eq    [2];
    bit         eb    [2];
    bit         ed    [2];
    bit         ep    [2];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Predict the effect of one clock edge on instance k given current inputs
    task automatic model(input int k);
        int idx;
        bit sw, wr, fwd;
        if (!rstb) begin
            for (int a = 0; a < 4; a++) begin
                mmem[k][a] = 8'hFF;
                mpar[k][a] = 1'b0;
            end
            eq[k] = 8'hFF; eb[k] = 1'b0; ed[k] = 1'b0; ep[k] = 1'b0; left[k] = 0;
        end else begin
            sw  = (left[k] > 0);
            idx = depth[k] - left[k];
            wr  = we && (int'(waddr) < depth[k]) && !(sw && int'(waddr) == idx);
            fwd = 1'b0;
            if (int'(raddr) >= depth[k]) begin
                eq[k] = 8'hFF;
            end else if (byp[k] && sw && int'(raddr) == idx) begin
                eq[k] = 8'hFF; fwd = 1'b1;
            end else if (byp[k] && wr && waddr == raddr) begin
                eq[k] = d; fwd = 1'b1;
            end else begin
                eq[k] = mmem[k][raddr];
            end
            ep[k] = (int'(raddr) < depth[k] && !fwd) ? ((^mmem[k][raddr]) ^ mpar[k][raddr]) : 1'b0;
            if (wr) begin
                mmem[k][waddr] = d;
                mpar[k][waddr] = (^d) ^ err_inj;
            end
            if (sw) begin
                mmem[k][idx] = 8'hFF;
                mpar[k][idx] = 1'b0;
            end
            ed[k] = (left[k] == 1);
            if (sw) left[k] = left[k] - 1;
            else if (setreq) left[k] = depth[k];
            eb[k] = (left[k] > 0);
        end
    endtask

    // Apply one cycle of stimulus and check both instances after the edge
    task automatic step(input bit r, input bit w, input logic [1:0] wa, input logic [7:0] dd,
                        input logic [1:0] ra, input bit sr, input bit ei);
        @(negedge clk);
        rstb = r; we = w; waddr = wa; d = dd; raddr = ra; setreq = sr; err_inj = ei;
        model(0);
        model(1);
        @(posedge clk);
        #1;
        chk("q0",    q0,           eq[0]);
        chk("qn0",   qn0,          ~eq[0]);
        chk("busy0", {7'd0, busy0}, {7'd0, eb[0]});
        chk("done0", {7'd0, done0}, {7'd0, ed[0]});
        chk("q1",    q1,           eq[1]);
        chk("qn1",   qn1,          ~eq[1]);
        chk("busy1", {7'd0, busy1}, {7'd0, eb[1]});
        chk("done1", {7'd0, done1}, {7'd0, ed[1]});
`ifdef LASX_BANK_PARITY_EN
        chk("perr0", {7'd0, perr0}, {7'd0, ep[0]});
        chk("perr1", {7'd0, perr1}, {7'd0, ep[1]});
`endif
    endtask

    initial begin
        rstb = 1'b0; we = 1'b0; waddr = 2'd0; d = 8'd0; raddr = 2'd0; setreq = 1'b0; err_inj = 1'b0;

        // Reset, then read every address
        step(1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 1'b0);
        for (int a = 0; a < 4; a++) step(1'b1, 1'b0, 2'd0, 8'h00, 2'(a), 1'b0, 1'b0);

        // Plain writes and reads
        step(1'b1, 1'b1, 2'd1, 8'h3C, 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'd2, 8'hA5, 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 8'h00, 2'd1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 8'h00, 2'd2, 1'b0, 1'b0);

        // Same-cycle write and read of address 2, then a plain read
        step(1'b1, 1'b1, 2'd2, 8'h11, 2'd2, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 8'h00, 2'd2, 1'b0, 1'b0);

        // Clear all entries, then sweep with writes on swept and unswept entries
        for (int a = 0; a < 4; a++) step(1'b1, 1'b1, 2'(a), 8'h00, 2'(a), 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 2'd0, 8'h00, 2'd1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 8'h77, 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'd3, 8'h77, 2'd3, 1'b1, 1'b0);
        step(1'b1, 1'b0, 2'd0, 8'h00, 2'd2, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 1'b0);
        for (int a = 0; a < 4; a++) step(1'b1, 1'b0, 2'd0, 8'h00, 2'(a), 1'b0, 1'b0);

        // Write colliding with the sweep pointer
        step(1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 2'd0, 8'h55, 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'd1, 8'h66, 2'd1, 1'b0, 1'b0);
        for (int a = 0; a < 4; a++) step(1'b1, 1'b0, 2'd0, 8'h00, 2'(a), 1'b0, 1'b0);

        // Abort a sweep with reset on its second cycle
        for (int a = 0; a < 4; a++) step(1'b1, 1'b1, 2'(a), 8'h00, 2'(a), 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 2'd0, 8'h00, 2'd3, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 8'h00, 2'd3, 1'b0, 1'b0);
        for (int a = 0; a < 4; a++) step(1'b1, 1'b0, 2'd0, 8'h00, 2'(a), 1'b0, 1'b0);

        // Parity corruption and clean rewrite at address 3
        step(1'b1, 1'b1, 2'd3, 8'h01, 2'd0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'd0, 8'h00, 2'd3, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'd3, 8'h01, 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 8'h00, 2'd3, 1'b0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 40) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 8'($urandom), 2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
